// File: rtl/delay_stim_pkg.sv
// rtl/delay_stim_pkg.sv - shared constants and types for the delay stimulus sequencer
package delay_stim_pkg;

   localparam int NUM_STEPS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic en_or;
      logic en_and;
      logic b;
      logic a;
   } pattern_t;

   // Entry 0 is the least significant nibble: C, D, F, E, C, F, B, 3
   localparam logic [NUM_STEPS-1:0][3:0] PATTERN = {
      4'h3,   // step 7: y_or goes to Z
      4'hB,   // step 6: y_and goes to Z
      4'hF,   // step 5: both rise
      4'hC,   // step 4: or falls
      4'hE,   // step 3: and falls
      4'hF,   // step 2: and rises
      4'hD,   // step 1: or rises
      4'hC    // step 0: both low, both enabled
   };

   function automatic pattern_t pattern_at(input logic [2:0] idx);
      return pattern_t'(PATTERN[idx]);
   endfunction

endpackage

// File: rtl/delay_stim_sequencer.sv
// rtl/delay_stim_sequencer.sv - steps the delay block inputs through a fixed held pattern
module delay_stim_sequencer
   import delay_stim_pkg::*;
#(
   parameter int HOLD_CYCLES = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       loop_en,
   output logic       a,
   output logic       b,
   output logic       en_and,
   output logic       en_or,
   output logic [2:0] step,
   output logic       busy,
   output logic       sample,
   output logic       done
);

   localparam int            CW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYCLES - 1);
   localparam logic [2:0]    LAST_STEP = 3'(NUM_STEPS - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    step_n;
   pattern_t      pat, pat_n;
   logic          busy_n;
   logic          sample_n;
   logic          done_n;

   // Outputs come straight from registers so nothing downstream sees an input-to-output path
   assign en_or  = pat.en_or;
   assign en_and = pat.en_and;
   assign b      = pat.b;
   assign a      = pat.a;

   // State, hold counter and every output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         step   <= '0;
         pat    <= '0;
         busy   <= 1'b0;
         sample <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         step   <= step_n;
         pat    <= pat_n;
         busy   <= busy_n;
         sample <= sample_n;
         done   <= done_n;
      end
   end

   // Next state plus the output values the registers take on the coming edge
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      step_n   = step;
      pat_n    = '0;
      busy_n   = 1'b0;
      sample_n = 1'b0;
      done_n   = 1'b0;

      unique case (state)
         IDLE: begin
            step_n = '0;
            cnt_n  = '0;
            if (start && !abort) begin
               state_n = RUN;
               cnt_n   = RELOAD;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               step_n  = '0;
               cnt_n   = '0;
            end else if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else if (step != LAST_STEP) begin
               step_n = step + 3'd1;
               cnt_n  = RELOAD;
            end else if (loop_en) begin
               step_n = '0;
               cnt_n  = RELOAD;
            end else begin
               state_n = DONE;
               step_n  = '0;
               cnt_n   = '0;
            end
         end
         DONE: begin
            // start here is dropped, not queued; abort lands in IDLE as well
            state_n = IDLE;
            step_n  = '0;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            step_n  = '0;
            cnt_n   = '0;
         end
      endcase

      // The strobe marks the final hold cycle, i.e. the cycle in which the counter reads 0
      if (state_n == RUN) begin
         pat_n    = pattern_at(step_n);
         busy_n   = 1'b1;
         sample_n = (cnt_n == '0);
      end
      done_n = (state_n == DONE);
   end

endmodule

// File: tb/tb_delay_stim_sequencer.sv
// tb/tb_delay_stim_sequencer.sv - randomized self-checking bench for delay_stim_sequencer
module tb_delay_stim_sequencer;

   localparam int H = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, loop_en;
   logic       a, b, en_and, en_or, busy, sample, done;
   logic [2:0] step;

   logic       start1, abort1, loop_en1;
   logic       a1, b1, en_and1, en_or1, busy1, sample1, done1;
   logic [2:0] step1;

   logic [9:0] obs;
   assign obs = {en_or, en_and, b, a, step, busy, sample, done};

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: mode 0 idle, 1 running, 2 done; pos counts cycles since the run began
   int m_mode = 0;
   int m_pos  = 0;
   logic [3:0] pat [8];

   delay_stim_sequencer #(.HOLD_CYCLES(H)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
      .a(a), .b(b), .en_and(en_and), .en_or(en_or), .step(step),
      .busy(busy), .sample(sample), .done(done)
   );

   delay_stim_sequencer #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .loop_en(loop_en1),
      .a(a1), .b(b1), .en_and(en_and1), .en_or(en_or1), .step(step1),
      .busy(busy1), .sample(sample1), .done(done1)
   );

   function automatic logic [9:0] exp_vec();
      int idx;
      idx = (m_pos / H) % 8;
      if (m_mode == 1)
         return {pat[idx], 3'(idx), 1'b1, (m_pos % H == H - 1), 1'b0};
      else if (m_mode == 2)
         return 10'b0000000001;
      else
         return 10'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (start && !abort) begin m_mode = 1; m_pos = 0; end
            1: begin
               if (abort) m_mode = 0;
               else if ((m_pos % (8 * H)) == (8 * H - 1) && !loop_en) m_mode = 2;
               else m_pos++;
            end
            default: m_mode = 0;
         endcase
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got %h exp 000", cyc, obs);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got %h exp %h", cyc, obs, exp_vec());
         end
      end
   endtask

   task automatic test_single_run();
      int done_at, samples;
      done_at = -1;
      samples = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8 * H + 3; k++) begin
         if (k > 1) tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_run off=%0d got %h exp %h", k, obs, exp_vec());
         end
         if (done === 1'b1) done_at = k;
         if (sample === 1'b1) samples++;
      end
      checks++;
      if (done_at !== 8 * H + 1) begin
         errors++;
         $display("FAIL single_done_offset got %0d exp %0d", done_at, 8 * H + 1);
      end
      checks++;
      if (samples !== 8) begin
         errors++;
         $display("FAIL single_sample_count got %0d exp 8", samples);
      end
   endtask

   task automatic test_loop();
      int done_at;
      bit busy_drop;
      done_at = -1;
      busy_drop = 0;
      loop_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 16 * H + 3; k++) begin
         if (k > 1) tick();
         if (k == 8 * H + 2 * H) loop_en = 1'b0;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL loop off=%0d got %h exp %h", k, obs, exp_vec());
         end
         if (k <= 16 * H && busy !== 1'b1) busy_drop = 1;
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      checks++;
      if (busy_drop) begin
         errors++;
         $display("FAIL loop_busy got dropped exp held");
      end
      checks++;
      if (done_at !== 16 * H + 1) begin
         errors++;
         $display("FAIL loop_done_offset got %0d exp %0d", done_at, 16 * H + 1);
      end
   endtask

   task automatic test_abort();
      bit saw_done;
      saw_done = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL abort_next got %h exp 000", obs);
      end
      tick();
      if (done === 1'b1) saw_done = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8 * H + 2; k++) begin
         if (k > 1) tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL abort_restart off=%0d got %h exp %h", k, obs, exp_vec());
         end
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_done got 1 exp 0");
      end
   endtask

   task automatic test_ignored_start();
      start = 1'b1;
      tick();
      for (int k = 1; k <= 8 * H + 3; k++) begin
         if (k > 1) tick();
         if (k < 8 * H + 1) start = 1'($urandom_range(0, 1));
         else if (k == 8 * H + 1) start = 1'b1;
         else start = 1'b0;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL ignored_start off=%0d got %h exp %h", k, obs, exp_vec());
         end
      end
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || obs !== 10'b0) begin
         errors++;
         $display("FAIL start_abort_idle got %h exp 000", obs);
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 5 * H + 2; k++) tick();
      checks++;
      if (step !== 3'd5) begin
         errors++;
         $display("FAIL mid_run_step got %0d exp 5", step);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL mid_run_reset got %h exp 000", obs);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL mid_run_after cyc=%0d got %h exp %h", cyc, obs, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         start   = ($urandom_range(0, 7) == 0);
         abort   = ($urandom_range(0, 63) == 0);
         loop_en = 1'($urandom_range(0, 1));
         rst     = ($urandom_range(0, 199) == 0);
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got %h exp %h", cyc, obs, exp_vec());
         end
      end
      start = 1'b0;
      abort = 1'b0;
      loop_en = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 8 * H * 2 + 4; k++) tick();
   endtask

   task automatic test_hold_one();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         checks++;
         if ({en_or1, en_and1, b1, a1, step1, busy1, sample1, done1} !==
             {pat[k-1], 3'(k - 1), 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_one step=%0d got %h%0d%b%b%b exp %h%0d110", k - 1,
                     {en_or1, en_and1, b1, a1}, step1, busy1, sample1, done1, pat[k-1], k - 1);
         end
      end
      tick();
      checks++;
      if ({en_or1, en_and1, b1, a1, busy1, sample1, done1} !== 7'b0000001) begin
         errors++;
         $display("FAIL hold_one_done got %b exp 0000001",
                  {en_or1, en_and1, b1, a1, busy1, sample1, done1});
      end
      tick();
      checks++;
      if ({en_or1, en_and1, b1, a1, step1, busy1, sample1, done1} !== 10'b0) begin
         errors++;
         $display("FAIL hold_one_idle got nonzero exp 000");
      end
   endtask

   initial begin
      pat[0] = 4'hC; pat[1] = 4'hD; pat[2] = 4'hF; pat[3] = 4'hE;
      pat[4] = 4'hC; pat[5] = 4'hF; pat[6] = 4'hB; pat[7] = 4'h3;
      rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; loop_en1 = 1'b0;
      test_reset();
      test_single_run();
      test_loop();
      test_abort();
      test_ignored_start();
      test_reset_mid_run();
      test_hold_one();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_stim_sequencer.md
# delay_stim_sequencer

Upstream stimulus stage for the gate-delay/tri-state datapath: drives the `a`, `b`, `en_and` and `en_or` inputs of the delay block through a fixed 8-step pattern. Each step is held for a programmable number of clock cycles so every rise, fall and turn-off delay settles before the next change. A one-cycle `sample` strobe at the end of each step tells a downstream checker when to capture `y_and` and `y_or`.

## Interface
- `HOLD_CYCLES`, default 8: cycles each pattern step is held; legal range ≥1; must exceed the worst-case gate delay (5 ns) divided by the clock period.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a run; sampled only in IDLE.
- `abort` input 1: synchronous abort; returns the block to IDLE next cycle with no `done`.
- `loop_en` input 1: restart at step 0 instead of finishing; sampled in the last cycle of step 7.
- `a`, `b` output 1 each: data inputs to the delay block.
- `en_and`, `en_or` output 1 each: tri-state enables to the delay block.
- `step` output 3: index of the pattern currently driven.
- `busy` output 1: high while a pattern is driven.
- `sample` output 1: one-cycle pulse in the last hold cycle of each step.
- `done` output 1: one-cycle pulse after a non-looping run completes.

## Operation
- States:
  - IDLE: all outputs 0.
  - RUN: drive `PATTERN[step]` and count hold cycles.
  - DONE: all pattern outputs 0, `done`=1, `busy`=0; lasts one cycle, then IDLE.
- Pattern ROM, 4 bits per entry as {en_or, en_and, b, a}:
  - step 0 = 4'hC, both low, both enabled
  - step 1 = 4'hD, or rises
  - step 2 = 4'hF, and rises
  - step 3 = 4'hE, and falls
  - step 4 = 4'hC, or falls
  - step 5 = 4'hF, both rise
  - step 6 = 4'hB, y_and goes to Z
  - step 7 = 4'h3, y_or goes to Z
- IDLE → RUN: `start`=1 and `abort`=0. Load `step`=0 and hold counter = HOLD_CYCLES-1.
- RUN: the counter decrements each cycle. When it reaches 0:
  - `sample`=1.
  - If `step`<7: `step`+1 and reload the counter.
  - If `step`==7 and `loop_en`=1: `step`=0 and reload the counter.
  - If `step`==7 and `loop_en`=0: go to DONE.
- `abort` in RUN or DONE → IDLE next cycle. No `sample` or `done` in the abort cycle's successor. `abort` wins over `start`.
- `start` while RUN or DONE is ignored and not queued.
- `rst`: state IDLE, `step`=0, counter 0, every output 0. A reset mid-run discards the run.
- Counter width: $clog2(HOLD_CYCLES+1); no wrap beyond HOLD_CYCLES-1.

## Timing
- All outputs are registered; no combinational path from input to output.
- `start` high at edge t → pattern 0 visible and `busy`=1 from cycle t+1.
- Each step is driven for exactly HOLD_CYCLES cycles. Patterns change on consecutive cycles with no gap.
- `sample` is asserted in cycle t+k·HOLD_CYCLES for k=1..8, coincident with the last cycle of each step.
- Non-looping run:
  - `busy` is high in cycles t+1 .. t+8·HOLD_CYCLES.
  - `done` is high in cycle t+8·HOLD_CYCLES+1.
  - IDLE from t+8·HOLD_CYCLES+2.
  - Earliest accepted restart: `start` in the DONE cycle is ignored; it must arrive in IDLE.
- Looping: step 0 follows step 7 with no idle cycle; `busy` stays high.
- HOLD_CYCLES=1: `sample` is high every RUN cycle and `step` advances every cycle.

## Structure
- Shared package `delay_stim_pkg` contains:
  - `NUM_STEPS`=8
  - the state enum {IDLE, RUN, DONE}
  - the `PATTERN` constant array of 4-bit entries
  - a `pattern_t` struct {en_or, en_and, b, a}
- No sub-module. The hold counter and the FSM live in one module; the pattern lookup is a package constant index.

## Test plan
- Reset/idle: hold `rst` 3 cycles, then idle 5 cycles → all outputs 0, `step`=0.
- Single run (HOLD_CYCLES=4, `start` at cycle 10):
  - {en_or,en_and,b,a} = C,D,F,E,C,F,B,3, each 4 cycles, from cycle 11.
  - `sample` at cycles 14, 18, …, 42.
  - `done` at 43; IDLE at 44.
- Loop: `loop_en`=1 through the first pass, then cleared during the second pass → pattern C at cycle 43 with `busy` held high; `done` only at cycle 75.
- Abort: `abort` at cycle 20 in a run started at 10 → outputs 0 and IDLE at 21, no `done`. A `start` at 22 restarts cleanly.
- Ignored start/priority:
  - `start` pulses during RUN do not change the step timing.
  - `start`+`abort` together in IDLE → stays IDLE.
- Reset mid-run and HOLD_CYCLES=1:
  - `rst` at step 5 → all outputs 0 next cycle.
  - Separate build with HOLD_CYCLES=1 → 8 consecutive patterns, `sample` high 8 cycles, `done` on cycle 9.
